// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data cache; fixed MEM_LAT-cycle access window, then a one-cycle done pulse.
module mem_port_arbiter #(
   parameter int MEM_LAT = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halted,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_q, last_d;   // also identifies the current owner (0 = I, 1 = D)
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              grant_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // On a tie, D wins unless D was the last one served.
   assign grant_d = d_req && (!i_req || !last_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (!halted && (i_req || d_req)) begin
               last_d  = grant_d;
               cnt_d   = '0;
               state_d = ACCESS;
               if (grant_d) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = i_addr;
                  we_d    = 1'b0;
                  wdata_d = '0;
               end
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               if (!we_q) begin
                  if (last_q) d_rdata_d = mem_rdata;
                  else        i_rdata_d = mem_rdata;
               end
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory outputs decode from state so reset drops them without a clock.
   assign mem_addr     = (state_q == ACCESS) ? addr_q  : '0;
   assign mem_wdata    = (state_q == ACCESS) ? wdata_q : '0;
   assign mem_write_en = (state_q == ACCESS) && we_q;
   assign i_done       = (state_q == RESP) && !last_q;
   assign d_done       = (state_q == RESP) && last_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected done events,
// a negedge monitor pops and checks requester, cycle and read data.
module tb_mem_port_arbiter;
   logic        clk = 1'b0, rst = 1'b1, halted = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] mem_rdata;
   logic        i_done, d_done, mem_write_en, busy;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   mem_port_arbiter #(.MEM_LAT(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(rst), .halted(halted),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: 0x400 holds the fetched instruction, everything else reads ~addr.
   assign mem_rdata = (mem_addr == 32'h400) ? 32'h2402000A : ~mem_addr;

   typedef struct {
      bit          d;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int vec = 0, miss = 0;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      vec++;
      if (a !== e) begin
         miss++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   task automatic push(bit d, logic [31:0] r, int c);
      exp_t e;
      e.d = d; e.rdata = r; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic nxt(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (i_done || d_done) begin
         if (sb.size() == 0) begin
            vec++;
            miss++;
            $display("FAIL unexpected_done: got i_done=%0b d_done=%0b expected none (cycle %0d)",
                     i_done, d_done, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_excl", 32'(i_done && d_done), 32'd0);
            chk("done_sel", 32'(d_done), 32'(e.d));
            chk("done_cycle", cyc, e.cyc);
            chk("rdata", e.d ? d_rdata : i_rdata, e.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      nxt(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we", 32'(mem_write_en), 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      rst = 1'b0;

      // single fetch
      i_addr = 32'h400; i_req = 1'b1; t = cyc;
      push(1'b0, 32'h2402000A, t + 5);
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("fetch_addr", mem_addr, 32'h400);
         chk("fetch_we", 32'(mem_write_en), 0);
         chk("fetch_busy", 32'(busy), 1);
      end
      nxt(); i_req = 1'b0;

      // data write, address changed mid-access
      nxt();
      d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_req = 1'b1; t = cyc;
      push(1'b1, 32'h0, t + 5);
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("wr_addr", mem_addr, 32'h100);
         chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
         chk("wr_we", 32'(mem_write_en), 1);
         if (k == 2) d_addr = 32'h200;
      end
      nxt(); d_req = 1'b0; d_we = 1'b0;

      // data read
      nxt();
      d_addr = 32'h500; d_req = 1'b1; t = cyc;
      push(1'b1, 32'hFFFFFAFF, t + 5);
      nxt(5); d_req = 1'b0;
      chk("i_rdata_held", i_rdata, 32'h2402000A);

      // halted raised mid-fetch, request kept high
      nxt();
      i_addr = 32'h400; i_req = 1'b1; t = cyc;
      push(1'b0, 32'h2402000A, t + 5);
      nxt(2); halted = 1'b1;
      nxt(3);
      for (int k = 1; k <= 4; k++) begin
         nxt();
         chk("halt_busy", 32'(busy), 0);
         chk("halt_addr", mem_addr, 0);
      end
      i_req = 1'b0; halted = 1'b0;

      // continuous contention from reset: D, I, D, I
      nxt();
      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_addr = 32'h400; d_addr = 32'h500;
      nxt();
      chk("rst2_busy", 32'(busy), 0);
      chk("rst2_d_rdata", d_rdata, 0);
      rst = 1'b0; t = cyc;
      push(1'b1, 32'hFFFFFAFF, t + 5);
      push(1'b0, 32'h2402000A, t + 11);
      push(1'b1, 32'hFFFFFAFF, t + 17);
      push(1'b0, 32'h2402000A, t + 23);
      nxt(12);
      chk("rr_idle_gap", 32'(busy), 0);
      nxt();
      chk("rr_busy", 32'(busy), 1);
      chk("rr_addr", mem_addr, 32'h500);
      nxt(10); i_req = 1'b0; d_req = 1'b0;
      nxt(2);
      chk("rr_end_busy", 32'(busy), 0);

      // reset mid-write aborts; held request restarts
      nxt();
      d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'h12345678; d_req = 1'b1;
      nxt(3);
      chk("abort_we_pre", 32'(mem_write_en), 1);
      rst = 1'b1;
      #1;
      chk("abort_we", 32'(mem_write_en), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_d_rdata", d_rdata, 0);
      nxt();
      rst = 1'b0; t = cyc;
      push(1'b1, 32'h0, t + 5);
      nxt(5); d_req = 1'b0; d_we = 1'b0;

      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0) break;
         nxt();
      end
      chk("sb_empty", sb.size(), 0);
      nxt(2);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
